dram_rmw_ctrl: RTL and testbench
================================

Name: dram_rmw_ctrl

Overview:
- Access controller for one data way of the 2-way set-associative cache.
- Sits between the hit/write-check logic and a synchronous-read single-port data RAM. That RAM has one address bus and whole-word writes only. Its read data is valid the cycle after the address is presented.
- The block serialises requests onto the RAM, returns read data with a valid pulse, and turns byte-masked writes into read-modify-write (RMW) sequences.

Parameters:
- AWIDTH, 3: RAM address width; depth = 2^AWIDTH.
- DWIDTH, 32: data word width; must be a multiple of 8.
- BWIDTH, DWIDTH/8: byte-enable width. Derived; do not override.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AWIDTH  word address.
- req_wdata  in  DWIDTH  write data.
- req_be  in  BWIDTH  byte enables; bit i covers data bits [8i+7:8i].
- rsp_valid  out  1  read data valid, one-cycle pulse.
- rsp_rdata  out  DWIDTH  read data; zero when rsp_valid = 0.
- wr_done  out  1  write retired, one-cycle pulse.
- ram_addr  out  AWIDTH  RAM address.
- ram_din  out  DWIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DWIDTH  RAM read data, from the address latched on the previous edge.

Behaviour:
- Clock and reset: single clock domain on "clock"; reset is synchronous and active-high on "reset".
- Handshake: a request is accepted when req_valid && req_ready at a rising edge. Request fields are sampled only in the accept cycle.
- States: IDLE, RD_DATA, RMW_WR.
- IDLE:
  - req_ready = 1.
  - ram_addr = req_addr, combinational.
  - ram_we and ram_din are set by the accepted request type below; otherwise ram_we = 0.
- Read accepted (req_we = 0):
  - ram_we = 0; go to RD_DATA.
- RD_DATA:
  - req_ready = 0; rsp_valid = 1; rsp_rdata = ram_dout; ram_we = 0.
  - Next state IDLE.
  - Read latency is 1 cycle from accept to rsp_valid; read throughput is one per 2 cycles.
- Full write accepted (req_be all ones):
  - ram_we = 1 and ram_din = req_wdata in the accept cycle.
  - Stay in IDLE; wr_done = 1 on the next cycle.
  - Back-to-back full writes run at 1 per cycle.
- Null write accepted (req_be = 0):
  - No RAM write (ram_we = 0); stay in IDLE; wr_done = 1 on the next cycle.
- Partial write accepted (req_be neither 0 nor all ones):
  - Accept cycle: ram_we = 0, which starts the read; capture addr, wdata and be into holding registers; go to RMW_WR.
- RMW_WR:
  - req_ready = 0; ram_addr = held addr; ram_we = 1.
  - ram_din byte i = held_be[i] ? held_wdata byte i : ram_dout byte i.
  - Next state IDLE; wr_done = 1 on the next cycle.
  - Total occupancy is 2 cycles.
- wr_done: registered, asserted exactly one cycle after the cycle in which the write retired (or, for a null write, the accept cycle). Never asserted together with rsp_valid for the same request.
- Ordering: requests complete in acceptance order. No reordering, no outstanding-request queue.
- Hazards: a read accepted the cycle after any write to the same address returns the new data; no bypass is needed.
- Reset:
  - While reset = 1, ram_we = 0 and req_ready = 0.
  - On the edge with reset = 1: state <= IDLE, wr_done <= 0, holding registers <= 0.
  - rsp_valid = 0 and rsp_rdata = 0 follow from state IDLE.
  - Reset during RD_DATA or RMW_WR abandons the operation: no RAM write, no response pulse.
- req_valid may drop without acceptance. A request presented while req_ready = 0 is not consumed.

Test Plan:
- Reset, then read addr 5 (RAM holds 0xA5A5_0000) -> rsp_valid one cycle after accept, rsp_rdata = 0xA5A5_0000; req_ready low for exactly one cycle.
- Full writes 0x1111_1111 @2, 0x2222_2222 @3 on consecutive cycles -> two wr_done pulses on consecutive cycles; later reads of 2 and 3 return those values.
- Addr 4 = 0xDEAD_BEEF; write 0x0000_12FF with be = 4'b0101 -> RAM word becomes 0xDE00_BE FF (0xDE00_BEFF); ram_we high only in RMW_WR; wr_done 2 cycles after accept.
- be = 0 write to addr 1 -> no ram_we pulse, addr 1 unchanged, wr_done next cycle.
- Partial write to addr 6, then immediate read of addr 6 (req_valid held) -> read accepted on the first IDLE cycle and returns the merged value.
- Assert reset in the RMW_WR cycle of a partial write to addr 7 -> ram_we = 0, addr 7 unchanged, no wr_done, req_ready = 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/dram_rmw_ctrl_if.sv
// Request/response and RAM-side bundle for one data way's access controller.
// The slave modport is the controller. The master modport is its environment:
// the requester plus the data RAM.
interface dram_rmw_ctrl_if #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DWIDTH = 32
);
    localparam int unsigned BWIDTH = DWIDTH / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [BWIDTH-1:0] req_be;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              wr_done;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, wr_done, ram_addr, ram_din, ram_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, wr_done, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/dram_rmw_ctrl.sv
// Access controller for one data way of a 2-way set-associative cache.
// It serialises requests onto a synchronous-read single-port RAM and returns
// read data. Byte-masked writes become a read cycle followed by a write cycle.
module dram_rmw_ctrl #(
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DWIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    dram_rmw_ctrl_if.slave    bus_io
);
    localparam int unsigned BWIDTH = DWIDTH / 8;

    typedef enum logic [1:0] {StIdle, StRdData, StRmwWr} state_e;

    state_e            state_q, state_d;
    logic              wr_done_q, wr_done_d;
    logic [AWIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DWIDTH-1:0] hold_wdata_q, hold_wdata_d;
    logic [BWIDTH-1:0] hold_be_q, hold_be_d;

    // Next-state, holding-register capture and all combinational outputs.
    always_comb begin
        state_d          = state_q;
        wr_done_d        = 1'b0;
        hold_addr_d      = hold_addr_q;
        hold_wdata_d     = hold_wdata_q;
        hold_be_d        = hold_be_q;
        bus_io.req_ready = 1'b0;
        bus_io.rsp_valid = 1'b0;
        bus_io.rsp_rdata = '0;
        bus_io.ram_addr  = bus_io.req_addr;
        bus_io.ram_din   = bus_io.req_wdata;
        bus_io.ram_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus_io.req_ready = !reset;
                if (bus_io.req_valid && !reset) begin
                    if (!bus_io.req_we) begin
                        // Address goes out now; data comes back next cycle.
                        state_d = StRdData;
                    end else if (bus_io.req_be == '1) begin
                        bus_io.ram_we = 1'b1;
                        wr_done_d     = 1'b1;
                    end else if (bus_io.req_be == '0) begin
                        wr_done_d = 1'b1;
                    end else begin
                        // The read of the old word starts in this cycle.
                        hold_addr_d  = bus_io.req_addr;
                        hold_wdata_d = bus_io.req_wdata;
                        hold_be_d    = bus_io.req_be;
                        state_d      = StRmwWr;
                    end
                end
            end
            StRdData: begin
                // Reset abandons the read without a response pulse.
                bus_io.rsp_valid = !reset;
                bus_io.rsp_rdata = reset ? '0 : bus_io.ram_dout;
                state_d          = StIdle;
            end
            StRmwWr: begin
                bus_io.ram_addr = hold_addr_q;
                bus_io.ram_we   = !reset;
                for (int i = 0; i < int'(BWIDTH); i++) begin
                    bus_io.ram_din[8*i +: 8] = hold_be_q[i] ? hold_wdata_q[8*i +: 8]
                                                            : bus_io.ram_dout[8*i +: 8];
                end
                wr_done_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.wr_done = wr_done_q;

    // State and holding registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_done_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_be_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_done_q    <= wr_done_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_be_q    <= hold_be_d;
        end
    end
endmodule

// File: tb/tb_dram_rmw_ctrl.sv
// Self-checking bench for dram_rmw_ctrl: directed cases plus random traffic.
// Expected responses go into a queue when requests are accepted; a monitor
// pops them when the controller produces rsp_valid or wr_done.
module tb_dram_rmw_ctrl;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;

    typedef struct {
        bit          is_rsp;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    logic [31:0] model[8];
    logic [31:0] mem[8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    dram_rmw_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    dram_rmw_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read single-port RAM, with a bench-side preload port.
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r = r + (new_w & (32'hFF << (8 * i)));
            else       r = r + (old_w & (32'hFF << (8 * i)));
        end
        return r;
    endfunction

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (bus.rsp_valid && bus.wr_done) begin
                total++; bad++;
                $display("FAIL overlap: rsp_valid and wr_done both 1 (cycle %0d)", cyc);
            end else if (bus.rsp_valid || bus.wr_done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected: rsp_valid=%0b wr_done=%0b want none (cycle %0d)",
                             bus.rsp_valid, bus.wr_done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind_is_rsp", {31'b0, bus.rsp_valid}, {31'b0, e.is_rsp});
                    chk("resp_cycle", cyc, e.cyc);
                    if (e.is_rsp) chk("rsp_rdata", bus.rsp_rdata, e.data);
                end
            end else begin
                chk("rdata_idle_zero", bus.rsp_rdata, 32'h0);
            end
        end
    end

    // Drive one request; returns just after the accepting edge (or after the
    // RMW write cycle for a partial write). req_valid is left high.
    task automatic issue(input bit we, input logic [2:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        int n = 0;
        int acc;
        logic [31:0] m = 0;
        bit partial;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        partial = we && be != 4'hF && be != 4'h0;
        @(negedge clock);
        while (!bus.req_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (!bus.req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready=0 want 1 within 20 cycles (cycle %0d)", cyc);
            bus.req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        chk("accept_ram_addr", {29'b0, bus.ram_addr}, {29'b0, a});
        if (!we) begin
            chk("rd_ram_we", {31'b0, bus.ram_we}, 32'h0);
            exp_q.push_back('{1'b1, model[a], acc});
        end else if (be == 4'hF) begin
            chk("full_ram_we", {31'b0, bus.ram_we}, 32'h1);
            chk("full_ram_din", bus.ram_din, d);
            model[a] = d;
            exp_q.push_back('{1'b0, 32'h0, acc});
        end else if (be == 4'h0) begin
            chk("null_ram_we", {31'b0, bus.ram_we}, 32'h0);
            exp_q.push_back('{1'b0, 32'h0, acc});
        end else begin
            chk("rmw_rd_ram_we", {31'b0, bus.ram_we}, 32'h0);
            m = merge(model[a], d, be);
            model[a] = m;
            exp_q.push_back('{1'b0, 32'h0, acc + 1});
        end
        @(posedge clock);
        #1;
        if (partial) begin
            @(negedge clock);
            chk("rmw_ram_we", {31'b0, bus.ram_we}, 32'h1);
            chk("rmw_ram_addr", {29'b0, bus.ram_addr}, {29'b0, a});
            chk("rmw_ram_din", bus.ram_din, m);
            chk("rmw_ready", {31'b0, bus.req_ready}, 32'h0);
        end
    endtask

    task automatic idle(input int k);
        bus.req_valid = 1'b0;
        repeat (k) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] be;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 3'd0;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_be    = 4'hF;

        // Preload RAM and model while reset is held.
        for (int i = 0; i < 8; i++) model[i] = $urandom;
        model[5] = 32'hA5A5_0000;
        model[4] = 32'hDEAD_BEEF;
        pl_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pl_addr = 3'(i);
            pl_data = model[i];
            @(posedge clock);
            #1;
        end
        pl_en = 1'b0;
        @(negedge clock);
        chk("reset_ready", {31'b0, bus.req_ready}, 32'h0);
        chk("reset_ram_we", {31'b0, bus.ram_we}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", {31'b0, bus.req_ready}, 32'h1);
        chk("post_reset_rsp", {31'b0, bus.rsp_valid}, 32'h0);
        chk("post_reset_done", {31'b0, bus.wr_done}, 32'h0);
        @(posedge clock);
        #1;

        // Read addr 5; ready must drop for exactly one cycle.
        issue(1'b0, 3'd5, 32'h0, 4'h0);
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("rd_busy_ready", {31'b0, bus.req_ready}, 32'h0);
        @(negedge clock);
        chk("rd_after_ready", {31'b0, bus.req_ready}, 32'h1);
        idle(1);

        // Back-to-back full writes, then read them back.
        issue(1'b1, 3'd2, 32'h1111_1111, 4'hF);
        issue(1'b1, 3'd3, 32'h2222_2222, 4'hF);
        issue(1'b0, 3'd2, 32'h0, 4'h0);
        issue(1'b0, 3'd3, 32'h0, 4'h0);
        idle(2);

        // Partial write on addr 4, then confirm the merged word.
        issue(1'b1, 3'd4, 32'h0000_12FF, 4'b0101);
        chk("model_rmw_4", model[4], 32'hDE00_BEFF);
        issue(1'b0, 3'd4, 32'h0, 4'h0);
        idle(2);

        // Null write to addr 1 leaves it unchanged.
        issue(1'b1, 3'd1, 32'hFFFF_FFFF, 4'h0);
        issue(1'b0, 3'd1, 32'h0, 4'h0);
        idle(2);

        // Partial write to 6 followed immediately by a read of 6.
        issue(1'b1, 3'd6, 32'hCAFE_F00D, 4'b1001);
        issue(1'b0, 3'd6, 32'h0, 4'h0);
        idle(3);

        // Reset in the RMW write cycle abandons the write to addr 7.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 3'd7;
        bus.req_wdata = 32'h1234_5678;
        bus.req_be    = 4'b0011;
        @(negedge clock);
        chk("rst_test_ready", {31'b0, bus.req_ready}, 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("rst_rmw_ram_we", {31'b0, bus.ram_we}, 32'h0);
        chk("rst_rmw_ready", {31'b0, bus.req_ready}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_after_ready", {31'b0, bus.req_ready}, 32'h1);
        chk("rst_after_done", {31'b0, bus.wr_done}, 32'h0);
        @(posedge clock);
        #1;
        issue(1'b0, 3'd7, 32'h0, 4'h0);
        idle(2);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0:       be = 4'hF;
                1:       be = 4'h0;
                default: begin
                    be = 4'($urandom_range(1, 14));
                end
            endcase
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, be);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        chk("queue_drained", exp_q.size(), 32'h0);
        for (int i = 0; i < 8; i++) chk($sformatf("final_mem_%0d", i), mem[i], model[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
